// File: rtl/branch_pc_unit.sv
// Fetch PC register and branch resolution: decides taken/not-taken, redirects the PC
// and holds a timed flush. Optional BRANCH_STATS_EN adds branch/taken counters.
module branch_pc_unit #(
  parameter int unsigned     PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [2:0]      br_op,
  input  logic [PC_W-1:0] br_pc,
  input  logic [16:0]     br_imm,
  input  logic [26:0]     jmp_target,
  input  logic [PC_W-1:0] jr_addr,
  input  logic            not_equal,
  input  logic            less_than,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic            redirect,
  output logic            link_we,
  output logic [PC_W-1:0] link_addr
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     taken_count
`endif
);

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_BNE  = 3'b001,
    OP_BLT  = 3'b010,
    OP_J    = 3'b011,
    OP_JAL  = 3'b100,
    OP_JR   = 3'b101,
    OP_BEX  = 3'b110,
    OP_RSVD = 3'b111
  } br_op_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            redirect_q, redirect_d;
  logic            link_we_q, link_we_d;
  logic [PC_W-1:0] link_addr_q, link_addr_d;

  br_op_e          op;
  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] target;
  logic            cond_br;
  logic            take_cond;
  logic            evaluate;
  logic            take;

  assign op       = br_op_e'(br_op);
  assign imm_sext = PC_W'($signed(br_imm));
  assign seq_pc   = pc_q + PC_W'(1);
  assign evaluate = (state_q == S_RUN) && br_valid && !stall;
  assign take     = evaluate && take_cond;

  // Branch decode: condition and target of the X-stage instruction.
  always_comb begin
    cond_br   = 1'b0;
    take_cond = 1'b0;
    target    = '0;
    case (op)
      OP_BNE: begin
        cond_br   = 1'b1;
        take_cond = not_equal;
        target    = br_pc + PC_W'(1) + imm_sext;
      end
      OP_BLT: begin
        cond_br   = 1'b1;
        take_cond = less_than;
        target    = br_pc + PC_W'(1) + imm_sext;
      end
      OP_BEX: begin
        cond_br   = 1'b1;
        take_cond = not_equal;
        target    = PC_W'(jmp_target);
      end
      OP_J, OP_JAL: begin
        take_cond = 1'b1;
        target    = PC_W'(jmp_target);
      end
      OP_JR: begin
        take_cond = 1'b1;
        target    = jr_addr;
      end
      default: begin
        take_cond = 1'b0;
      end
    endcase
  end

  // State register, including the registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      pc_q        <= RESET_PC;
      flush_q     <= 1'b0;
      redirect_q  <= 1'b0;
      link_we_q   <= 1'b0;
      link_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
    end
  end

  // Next-state logic. A single-cycle flush never leaves RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (take) begin
          cnt_d = 3'(FLUSH_CYCLES - 1);
          if (FLUSH_CYCLES > 1) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!stall) begin
          if (cnt_q == 3'd0) state_d = S_RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Output logic: next values of the registered PC, flush and pulse outputs.
  always_comb begin
    pc_d        = pc_q;
    flush_d     = flush_q;
    redirect_d  = take;
    link_we_d   = take && (op == OP_JAL);
    link_addr_d = link_addr_q;
    if (link_we_d) link_addr_d = br_pc + PC_W'(1);
    case (state_q)
      S_RUN: begin
        if (!stall) begin
          if (take) begin
            pc_d    = target;
            flush_d = 1'b1;
          end else begin
            pc_d    = seq_pc;
            flush_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        if (!stall) begin
          pc_d = seq_pc;
          if (cnt_q == 3'd0) flush_d = 1'b0;
        end
      end
      default: begin
        flush_d = 1'b0;
      end
    endcase
  end

  assign pc        = pc_q;
  assign flush     = flush_q;
  assign redirect  = redirect_q;
  assign link_we   = link_we_q;
  assign link_addr = link_addr_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q;
  logic [31:0] taken_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      if (evaluate && cond_br && (br_count_q != '1))
        br_count_q <= br_count_q + 32'd1;
      if (take && cond_br && (taken_count_q != '1))
        taken_count_q <= taken_count_q + 32'd1;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: directed steps push hand-computed expectations,
// a monitor pops and compares one entry per clock after the rising edge.
module tb_branch_pc_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_op = 3'b000;
  logic [31:0] br_pc = '0;
  logic [16:0] br_imm = '0;
  logic [26:0] jmp_target = '0;
  logic [31:0] jr_addr = '0;
  logic        not_equal = 1'b0;
  logic        less_than = 1'b0;
  logic [31:0] pc;
  logic        flush;
  logic        redirect;
  logic        link_we;
  logic [31:0] link_addr;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] taken_count;
`endif

  branch_pc_unit #(
    .PC_W        (32),
    .RESET_PC    (32'h0),
    .FLUSH_CYCLES(2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_op     (br_op),
    .br_pc     (br_pc),
    .br_imm    (br_imm),
    .jmp_target(jmp_target),
    .jr_addr   (jr_addr),
    .not_equal (not_equal),
    .less_than (less_than),
    .pc        (pc),
    .flush     (flush),
    .redirect  (redirect),
    .link_we   (link_we),
    .link_addr (link_addr)
`ifdef BRANCH_STATS_EN
    ,
    .br_count   (br_count),
    .taken_count(taken_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        flush;
    logic        redirect;
    logic        link_we;
    logic [31:0] link_addr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_la = '0;

  localparam logic [2:0] NONE = 3'b000, BNE = 3'b001, BLT = 3'b010, J = 3'b011,
                         JAL = 3'b100, JR = 3'b101, BEX = 3'b110, RSVD = 3'b111;

  // Monitor: one expected entry per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e.pc || flush !== e.flush || redirect !== e.redirect ||
            link_we !== e.link_we || link_addr !== e.link_addr) begin
          n_err++;
          $display("FAIL %s: got pc=%h flush=%b redirect=%b link_we=%b link_addr=%h, want pc=%h flush=%b redirect=%b link_we=%b link_addr=%h",
                   e.name, pc, flush, redirect, link_we, link_addr,
                   e.pc, e.flush, e.redirect, e.link_we, e.link_addr);
        end
      end
    end
  end

  task automatic drive(input string nm, input logic rst, input logic st, input logic v,
                       input logic [2:0] op, input logic [31:0] bpc, input logic [16:0] imm,
                       input logic [26:0] jt, input logic [31:0] jr, input logic ne,
                       input logic lt, input logic [31:0] epc, input logic ef,
                       input logic er, input logic el);
    exp_t e;
    @(negedge clock);
    reset = rst; stall = st; br_valid = v; br_op = op; br_pc = bpc; br_imm = imm;
    jmp_target = jt; jr_addr = jr; not_equal = ne; less_than = lt;
    e.name = nm; e.pc = epc; e.flush = ef; e.redirect = er; e.link_we = el;
    e.link_addr = exp_la;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [31:0] epc, input logic ef);
    drive(nm, 0, 0, 0, NONE, 0, 0, 0, 0, 0, 0, epc, ef, 0, 0);
  endtask

  initial begin
    // 1: reset then sequential fetch
    exp_la = 32'h0;
    drive("reset", 1, 0, 0, NONE, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    idle("seq1", 32'h1, 0);
    idle("seq2", 32'h2, 0);
    idle("seq3", 32'h3, 0);
    idle("seq4", 32'h4, 0);
    // 2: bne taken with negative offset, two-cycle flush, then not taken
    drive("bne_taken", 0, 0, 1, BNE, 32'h10, 17'h1FFFC, 0, 0, 1, 0, 32'h0D, 1, 1, 0);
    idle("bne_flush1", 32'h0E, 1);
    idle("bne_flush_end", 32'h0F, 0);
    idle("pre_bne_nt", 32'h10, 0);
    drive("bne_not_taken", 0, 0, 1, BNE, 32'h10, 17'h1FFFC, 0, 0, 0, 0, 32'h11, 0, 0, 0);
    // 3: jal links; a taken branch during flush is squashed
    exp_la = 32'h21;
    drive("jal", 0, 0, 1, JAL, 32'h20, 0, 27'h100, 0, 0, 0, 32'h100, 1, 1, 1);
    drive("bne_in_flush", 0, 0, 1, BNE, 32'h50, 17'h8, 0, 0, 1, 0, 32'h101, 1, 0, 0);
    idle("jal_flush_end", 32'h102, 0);
    // 4: taken blt held off by stall
    drive("blt_stall1", 0, 1, 1, BLT, 32'h30, 17'h5, 0, 0, 0, 1, 32'h102, 0, 0, 0);
    drive("blt_stall2", 0, 1, 1, BLT, 32'h30, 17'h5, 0, 0, 0, 1, 32'h102, 0, 0, 0);
    drive("blt_stall3", 0, 1, 1, BLT, 32'h30, 17'h5, 0, 0, 0, 1, 32'h102, 0, 0, 0);
    drive("blt_taken", 0, 0, 1, BLT, 32'h30, 17'h5, 0, 0, 0, 1, 32'h36, 1, 1, 0);
    idle("blt_flush1", 32'h37, 1);
    idle("blt_flush_end", 32'h38, 0);
    // 5: stall inside flush freezes pc and counter; reset mid-flush wins
    drive("j_taken", 0, 0, 1, J, 32'h40, 0, 27'h200, 0, 0, 0, 32'h200, 1, 1, 0);
    drive("flush_stall1", 0, 1, 0, NONE, 0, 0, 0, 0, 0, 0, 32'h200, 1, 0, 0);
    drive("flush_stall2", 0, 1, 0, NONE, 0, 0, 0, 0, 0, 0, 32'h200, 1, 0, 0);
    idle("flush_cnt_dec", 32'h201, 1);
    drive("flush_stall3", 0, 1, 0, NONE, 0, 0, 0, 0, 0, 0, 32'h201, 1, 0, 0);
    idle("flush_exit", 32'h202, 0);
    drive("j_again", 0, 0, 1, J, 32'h60, 0, 27'h300, 0, 0, 0, 32'h300, 1, 1, 0);
    exp_la = 32'h0;
    drive("reset_mid_flush", 1, 0, 1, JAL, 32'h70, 0, 27'h500, 0, 1, 1, 32'h0, 0, 0, 0);
    idle("post_reset", 32'h1, 0);
    // jr, bex, reserved/none ops and invalid slots
    drive("jr_taken", 0, 0, 1, JR, 32'h80, 0, 0, 32'h1234, 0, 0, 32'h1234, 1, 1, 0);
    idle("jr_flush1", 32'h1235, 1);
    idle("jr_flush_end", 32'h1236, 0);
    drive("bex_not_taken", 0, 0, 1, BEX, 32'h90, 0, 27'h400, 0, 0, 0, 32'h1237, 0, 0, 0);
    drive("bex_taken", 0, 0, 1, BEX, 32'h90, 0, 27'h400, 0, 1, 0, 32'h400, 1, 1, 0);
    idle("bex_flush1", 32'h401, 1);
    idle("bex_flush_end", 32'h402, 0);
    drive("rsvd_op", 0, 0, 1, RSVD, 32'hA0, 17'h3, 27'h7, 32'h9, 1, 1, 32'h403, 0, 0, 0);
    drive("none_op", 0, 0, 1, NONE, 32'hA0, 17'h3, 27'h7, 32'h9, 1, 1, 32'h404, 0, 0, 0);
    drive("j_bubble", 0, 0, 0, J, 32'hA0, 0, 27'h700, 0, 0, 0, 32'h405, 0, 0, 0);
    // 6: target wraps modulo 2^32
    drive("bne_wrap", 0, 0, 1, BNE, 32'hFFFFFFFF, 17'h0, 0, 0, 1, 0, 32'h0, 1, 1, 0);
    idle("wrap_flush1", 32'h1, 1);
    idle("wrap_flush_end", 32'h2, 0);
    drive("blt_not_taken", 0, 0, 1, BLT, 32'hB0, 17'h10, 0, 0, 0, 0, 32'h3, 0, 0, 0);
    idle("final", 32'h4, 0);

    for (int unsigned i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
`ifdef BRANCH_STATS_EN
    // Since the last reset: bex nt, bex t, bne wrap t, blt nt.
    n_cmp++;
    if (br_count !== 32'd4 || taken_count !== 32'd2) begin
      n_err++;
      $display("FAIL stats: got br_count=%0d taken_count=%0d, want 4 and 2",
               br_count, taken_count);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
